quad_decoder: RTL and testbench
===============================

Name: quad_decoder

Overview:
- Quadrature (A/B) incremental-encoder decoder that feeds a position count. It turns two asynchronous phase inputs into single-cycle step/direction pulses and a wrapping up/down position counter.
- Its count and control semantics (syn_clr, load, en, max_tick, min_tick) match the team's up/down binary counter.
- It sits between off-chip encoder pins and the control logic, and is the decode end of the encoder-to-counter path.

Parameters:
- N, 8, width of the position counter.
- SYNC_STAGES, 2, number of synchronizer flops per channel (minimum 2).
- FILT, 3, consecutive clk cycles a synchronized level must hold before it is accepted (minimum 1).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-high.
- a_in  in  1  encoder phase A, asynchronous.
- b_in  in  1  encoder phase B, asynchronous.
- syn_clr  in  1  synchronous clear of pos and err.
- load  in  1  synchronous load of pos from d.
- d  in  N  load value.
- en  in  1  enables counting of decoded steps.
- step  out  1  one-cycle pulse per valid quadrature transition.
- dir  out  1  direction of the last step; 1 = forward/up, 0 = reverse/down.
- err  out  1  sticky illegal-transition flag.
- pos  out  N  position count.
- max_tick  out  1  pos == all ones.
- min_tick  out  1  pos == 0.

Behaviour:
- Reset (rst_n=1, asynchronous, overrides everything):
  - Synchronizer flops, filter counters, filtered A/B and previous phase all go to 0.
  - step=0, dir=1, err=0, pos=0.
  - On release, phase 00 is taken as the current phase and no step is generated.
- Synchronizer: each channel passes through SYNC_STAGES flops. No logic is allowed before the last stage.
- Filter, per channel:
  - While the synchronized value equals the filtered value, the filter counter is 0.
  - While it differs, the counter increments each cycle.
  - When the counter reaches FILT-1 and the value still differs, the filtered value takes the synchronized value on that edge and the counter returns to 0.
  - A glitch shorter than FILT cycles never reaches the filtered value.
- Latency: a raw level stable from before edge k gives a new filtered value after edge k+SYNC_STAGES+FILT-1, and step is high during the cycle after edge k+SYNC_STAGES+FILT.
- Phase decode compares the previous filtered {A,B} with the current one:
  - Forward sequence is 00→01→11→10→00. One forward transition gives step=1, dir=1.
  - The reverse of any forward transition gives step=1, dir=0.
  - Both bits changing in the same cycle gives step=0 and sets err; dir is unchanged; previous phase takes the current value.
  - No change gives step=0.
- step, dir and err are registered outputs. dir holds its value between steps.
- Counter, one priority order per edge:
  - syn_clr: pos=0 and err=0. It takes priority even if an illegal transition occurs in the same cycle.
  - else load: pos=d, and any simultaneous step is dropped.
  - else en & step: pos+1 if dir=1, pos-1 if dir=0.
  - Counting uses the dir value that accompanies the current step pulse, not the stale value.
- Wrap-around is modulo 2^N: all ones +1 → 0, and 0 −1 → all ones.
- max_tick and min_tick are combinational decodes of pos.
- A step with en=0 is still reported on step/dir but pos is held.
- err is cleared only by syn_clr or reset.
- Reset mid-operation: all state is discarded immediately. After release, a filtered value of 01 (for example) produces a normal step relative to the reset phase 00.

Decomposition:
- Shared package quad_pkg holds:
  - the phase constants PH_00, PH_01, PH_11, PH_10;
  - a function next_fwd(phase) returning the forward successor;
  - localparam DIR_UP=1, DIR_DN=0.
- One sub-module, quad_filter (synchronizer plus filter for one channel, parameters SYNC_STAGES and FILT), instantiated once for A and once for B.
- Phase decode and the counter stay in quad_decoder.

Test Plan:
- Reset, then drive the forward sequence 00→01→11→10→00 with each level held 10 cycles, with N=3 and en=1 → four step pulses, dir=1, pos 0→1→2→3→4; max_tick stays 0.
- load=1 with d=3'b110 for one cycle, then six forward steps → pos 6,7,0,1,2,…; max_tick=1 while pos=7; 7→0 wraps.
- From pos=1, drive the reverse sequence 00→10→11→01→00 → pos 0 then 7; min_tick=1 at 0; dir=0; pos 7 follows 0 (wrap).
- 2-cycle pulse on a_in with FILT=3 → no step and pos unchanged. Then jump A and B together 00→11 (held) → err=1, step=0; syn_clr → err=0 and pos=0.
- en=0 across three forward steps → three step pulses, pos unchanged. Assert load and a step edge in the same cycle → pos=d and the step is not counted.
- Assert rst_n=1 midway through a filter count, release, then hold 01 → first step at exactly SYNC_STAGES+FILT+1 cycles after the stable edge; pos=1, dir=1.

Source files
------------

// File: rtl/quad_pkg.sv
// Shared phase encoding and direction constants for the quadrature decoder.
package quad_pkg;

    localparam logic [1:0] PH_00 = 2'b00;
    localparam logic [1:0] PH_01 = 2'b01;
    localparam logic [1:0] PH_11 = 2'b11;
    localparam logic [1:0] PH_10 = 2'b10;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    // Forward rotation walks the Gray sequence 00 -> 01 -> 11 -> 10 -> 00.
    function automatic logic [1:0] next_fwd(input logic [1:0] phase);
        logic [1:0] nxt;
        nxt = PH_00;
        case (phase)
            PH_00:   nxt = PH_01;
            PH_01:   nxt = PH_11;
            PH_11:   nxt = PH_10;
            default: nxt = PH_00;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/quad_filter.sv
// One encoder channel: a synchronizer chain, then a level filter that accepts
// the synchronized value only after it has differed for FILT consecutive cycles.
module quad_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int FILT        = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic filt
);

    localparam int CW = (FILT > 1) ? $clog2(FILT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(FILT - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          cnt;
    logic                   synced;

    // Nothing but flops ahead of the last synchronizer stage.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
        end
    end

    assign synced = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            cnt  <= '0;
            filt <= 1'b0;
        end else if (synced == filt) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            filt <= synced;
            cnt  <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/quad_decoder.sv
// Quadrature A/B decoder: filtered phases produce step/dir pulses that drive
// a wrapping up/down position counter with clear/load/enable control.
module quad_decoder #(
    parameter int N           = 8,
    parameter int SYNC_STAGES = 2,
    parameter int FILT        = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         a_in,
    input  logic         b_in,
    input  logic         syn_clr,
    input  logic         load,
    input  logic [N-1:0] d,
    input  logic         en,
    output logic         step,
    output logic         dir,
    output logic         err,
    output logic [N-1:0] pos,
    output logic         max_tick,
    output logic         min_tick
);

    import quad_pkg::*;

    logic       a_filt;
    logic       b_filt;
    logic [1:0] cur_ph;
    logic [1:0] prev_ph;
    logic       is_fwd;
    logic       is_rev;
    logic       is_ill;

    quad_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT(FILT)) u_filt_a (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (a_in),
        .filt  (a_filt)
    );

    quad_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT(FILT)) u_filt_b (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (b_in),
        .filt  (b_filt)
    );

    assign cur_ph = {a_filt, b_filt};

    always_comb begin
        is_fwd = (cur_ph == next_fwd(prev_ph));
        is_rev = (prev_ph == next_fwd(cur_ph));
        is_ill = (cur_ph != prev_ph) && !is_fwd && !is_rev;
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            prev_ph <= PH_00;
            step    <= 1'b0;
            dir     <= DIR_UP;
            err     <= 1'b0;
        end else begin
            prev_ph <= cur_ph;
            step    <= is_fwd | is_rev;
            if (is_fwd) begin
                dir <= DIR_UP;
            end else if (is_rev) begin
                dir <= DIR_DN;
            end
            if (syn_clr) begin
                err <= 1'b0;
            end else if (is_ill) begin
                err <= 1'b1;
            end
        end
    end

    // The registered step/dir pair is consumed together, so a direction
    // reversal is counted with its own dir and never the previous one.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            pos <= '0;
        end else if (syn_clr) begin
            pos <= '0;
        end else if (load) begin
            pos <= d;
        end else if (en && step) begin
            pos <= (dir == DIR_UP) ? pos + 1'b1 : pos - 1'b1;
        end
    end

    assign max_tick = (pos == {N{1'b1}});
    assign min_tick = (pos == '0);

endmodule

// File: tb/tb_quad_decoder.sv
// Directed bench for quad_decoder with N=3, SYNC_STAGES=2, FILT=3.
module tb_quad_decoder;

    logic       clk;
    logic       rst_n;
    logic       a_in;
    logic       b_in;
    logic       syn_clr;
    logic       load;
    logic [2:0] d;
    logic       en;
    logic       step;
    logic       dir;
    logic       err;
    logic [2:0] pos;
    logic       max_tick;
    logic       min_tick;

    int checks   = 0;
    int failures = 0;

    int   steps;
    logic last_dir;
    logic max_seen;
    logic min_seen;
    logic [2:0] exp_pos;
    logic [1:0] seq [6];

    quad_decoder #(.N(3), .SYNC_STAGES(2), .FILT(3)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .a_in     (a_in),
        .b_in     (b_in),
        .syn_clr  (syn_clr),
        .load     (load),
        .d        (d),
        .en       (en),
        .step     (step),
        .dir      (dir),
        .err      (err),
        .pos      (pos),
        .max_tick (max_tick),
        .min_tick (min_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Drive a phase at a falling edge and watch n rising edges go by.
    task automatic hold(input logic a, input logic b, input int n);
        a_in     = a;
        b_in     = b;
        steps    = 0;
        max_seen = 1'b0;
        min_seen = 1'b0;
        repeat (n) begin
            @(negedge clk);
            if (step) begin
                steps++;
                last_dir = dir;
            end
            if (max_tick) max_seen = 1'b1;
            if (min_tick) min_seen = 1'b1;
        end
    endtask

    initial begin
        rst_n = 1'b1; a_in = 1'b0; b_in = 1'b0;
        syn_clr = 1'b0; load = 1'b0; d = '0; en = 1'b1;
        last_dir = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_pos", pos, 0);
        check("reset_dir", dir, 1);
        check("reset_err", err, 0);
        check("reset_step", step, 0);
        check("reset_min", min_tick, 1);
        check("reset_max", max_tick, 0);
        rst_n = 1'b0;
        repeat (4) @(negedge clk);
        check("idle_after_release_pos", pos, 0);

        // Forward 00->01->11->10->00
        seq[0] = 2'b01; seq[1] = 2'b11; seq[2] = 2'b10; seq[3] = 2'b00;
        for (int i = 0; i < 4; i++) begin
            hold(seq[i][1], seq[i][0], 10);
            check("fwd_steps", steps, 1);
            check("fwd_dir", last_dir, 1);
            check("fwd_pos", pos, i + 1);
            check("fwd_max", max_seen, 0);
        end

        // Load 6 then six forward steps across the wrap
        load = 1'b1; d = 3'b110;
        @(negedge clk);
        load = 1'b0;
        check("load6_pos", pos, 6);
        seq[0] = 2'b01; seq[1] = 2'b11; seq[2] = 2'b10;
        seq[3] = 2'b00; seq[4] = 2'b01; seq[5] = 2'b11;
        exp_pos = 3'd6;
        for (int i = 0; i < 6; i++) begin
            hold(seq[i][1], seq[i][0], 10);
            exp_pos = exp_pos + 3'd1;
            check("wrap_up_pos", pos, exp_pos);
            check("wrap_up_max", max_tick, (exp_pos == 3'd7));
            check("wrap_up_min", min_tick, (exp_pos == 3'd0));
        end
        hold(1'b1, 1'b0, 10);
        hold(1'b0, 1'b0, 10);
        check("back_to_00_pos", pos, 6);

        // From pos=1, reverse 00->10->11->01->00
        load = 1'b1; d = 3'b001;
        @(negedge clk);
        load = 1'b0;
        check("load1_pos", pos, 1);
        seq[0] = 2'b10; seq[1] = 2'b11; seq[2] = 2'b01; seq[3] = 2'b00;
        exp_pos = 3'd1;
        for (int i = 0; i < 4; i++) begin
            hold(seq[i][1], seq[i][0], 10);
            exp_pos = exp_pos - 3'd1;
            check("rev_steps", steps, 1);
            check("rev_dir", last_dir, 0);
            check("rev_pos", pos, exp_pos);
            check("rev_min", min_tick, (exp_pos == 3'd0));
            check("rev_max", max_tick, (exp_pos == 3'd7));
        end

        // 2-cycle glitch on A is rejected
        a_in = 1'b1;
        repeat (2) @(negedge clk);
        hold(1'b0, 1'b0, 10);
        check("glitch_steps", steps, 0);
        check("glitch_pos", pos, 5);

        // Both phases jump together: illegal
        hold(1'b1, 1'b1, 10);
        check("illegal_steps", steps, 0);
        check("illegal_err", err, 1);
        check("illegal_dir_kept", dir, 0);
        check("illegal_pos", pos, 5);
        syn_clr = 1'b1;
        @(negedge clk);
        syn_clr = 1'b0;
        check("clr_err", err, 0);
        check("clr_pos", pos, 0);

        // en=0: steps reported, pos held
        en = 1'b0;
        seq[0] = 2'b10; seq[1] = 2'b00; seq[2] = 2'b01;
        for (int i = 0; i < 3; i++) begin
            hold(seq[i][1], seq[i][0], 10);
            check("en0_steps", steps, 1);
            check("en0_dir", last_dir, 1);
            check("en0_pos", pos, 0);
        end
        en = 1'b1;

        // load coinciding with a step pulse wins and drops the step
        a_in = 1'b1; b_in = 1'b1;
        repeat (5) @(negedge clk);
        check("lat_step_early", step, 0);
        @(negedge clk);
        check("lat_step_on", step, 1);
        load = 1'b1; d = 3'b011;
        @(negedge clk);
        load = 1'b0;
        check("load_vs_step_pos", pos, 3);
        hold(1'b1, 1'b1, 5);
        check("load_vs_step_hold", pos, 3);

        // Reset mid-way through a filter count
        a_in = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        a_in = 1'b0; b_in = 1'b0;
        @(negedge clk);
        check("midrst_pos", pos, 0);
        check("midrst_dir", dir, 1);
        check("midrst_step", step, 0);
        rst_n = 1'b0;
        b_in = 1'b1;
        repeat (5) @(negedge clk);
        check("post_rst_step_early", step, 0);
        @(negedge clk);
        check("post_rst_step_on", step, 1);
        check("post_rst_dir", dir, 1);
        @(negedge clk);
        check("post_rst_pos", pos, 1);
        check("post_rst_err", err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
